// File: rtl/data_cache_m.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Read hits are served combinationally; refills and store write-throughs stall the pipeline.
module data_cache_m #(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReadEn,
  input  logic             iWriteEn,
  input  logic [31:0]      iAddress,
  input  logic [31:0]      iWriteData,
  input  logic [3:0]       iByteEn,
  input  logic             iInvalidate,
  output logic [31:0]      oReadData,
  output logic             oStallM,
  output logic             oMemReq,
  output logic             oMemWe,
  output logic [31:0]      oMemAddr,
  output logic [31:0]      oMemWData,
  output logic [3:0]       oMemBe,
  input  logic             iMemAck,
  input  logic [31:0]      iMemRData,
  output logic [CNT_W-1:0] oHitCount,
  output logic [CNT_W-1:0] oMissCount
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned FW = IW + OW;
  localparam int unsigned TW = 30 - FW;
  localparam int unsigned LW = 30 - OW;
  localparam int unsigned KW = (OW == 0) ? 1 : OW;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  state_e           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LW-1:0]    line_q, line_d;
  logic             replay_q, replay_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [TW-1:0] tag_ram  [SETS];
  logic [31:0]   data_ram [SETS*LINE_WORDS];

  logic [FW-1:0] word_idx;
  logic [IW-1:0] set_idx;
  logic [TW-1:0] addr_tag;
  logic [IW-1:0] fill_set;
  logic [FW-1:0] fill_idx;
  logic [31:0]   refill_addr;
  logic          hit;
  logic          is_store;
  logic          is_load;
  logic          last_word;
  logic          fill_we;
  logic          tag_we;
  logic          merge_we;

  assign word_idx    = iAddress[FW+1:2];
  assign set_idx     = iAddress[FW+1:OW+2];
  assign addr_tag    = iAddress[31:FW+2];
  assign fill_set    = line_q[IW-1:0];
  assign fill_idx    = (FW'(fill_set) << OW) | FW'(k_q);
  assign refill_addr = {line_q, {(OW+2){1'b0}}} | (32'(k_q) << 2);
  assign hit         = valid_q[set_idx] && (tag_ram[set_idx] == addr_tag);
  assign is_store    = iWriteEn;
  assign is_load     = iReadEn && !iWriteEn;
  assign last_word   = (k_q == KW'(LINE_WORDS - 1));
  assign oReadData   = data_ram[word_idx];
  assign oHitCount   = hit_cnt_q;
  assign oMissCount  = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    k_d        = k_q;
    line_d     = line_q;
    replay_d   = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    oStallM    = 1'b0;
    oMemReq    = 1'b0;
    oMemWe     = 1'b0;
    oMemAddr   = '0;
    oMemWData  = '0;
    oMemBe     = '0;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    merge_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iInvalidate) begin
          // The access presented alongside the fence is re-evaluated next cycle.
          valid_d = '0;
          oStallM = iReadEn || iWriteEn;
        end else if (is_store) begin
          oStallM = 1'b1;
          state_d = StWrite;
        end else if (is_load) begin
          if (hit) begin
            // The replayed load after a refill is not counted a second time.
            if (!replay_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            oStallM          = 1'b1;
            state_d          = StRefill;
            k_d              = '0;
            line_d           = iAddress[31:OW+2];
            valid_d[set_idx] = 1'b0;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      StRefill: begin
        oStallM  = 1'b1;
        oMemReq  = 1'b1;
        oMemAddr = refill_addr;
        if (iMemAck) begin
          fill_we = 1'b1;
          k_d     = k_q + KW'(1);
          if (last_word) begin
            k_d               = '0;
            tag_we            = 1'b1;
            valid_d[fill_set] = 1'b1;
            replay_d          = 1'b1;
            state_d           = StIdle;
          end
        end
      end
      StWrite: begin
        oMemReq   = 1'b1;
        oMemWe    = 1'b1;
        oMemAddr  = {iAddress[31:2], 2'b00};
        oMemWData = iWriteData;
        oMemBe    = iByteEn;
        oStallM   = !iMemAck;
        if (iMemAck) begin
          merge_we = hit;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      k_q        <= '0;
      line_q     <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      k_q        <= k_d;
      line_q     <= line_d;
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data storage is deliberately not reset; valid bits guard it.
  always_ff @(posedge iClk) begin
    if (!iRst && fill_we) data_ram[fill_idx] <= iMemRData;
    if (!iRst && tag_we) tag_ram[fill_set] <= line_q[LW-1:IW];
    if (!iRst && merge_we) begin
      for (int b = 0; b < 4; b++) begin
        if (iByteEn[b]) data_ram[word_idx][8*b +: 8] <= iWriteData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_cache_m.sv
// Randomized self-checking bench for data_cache_m against a line-residency model and a
// backing-memory model; loads must always return current memory contents.
module tb_data_cache_m;

  localparam int unsigned SETS       = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  logic             iClk, iRst, iReadEn, iWriteEn, iInvalidate;
  logic [31:0]      iAddress, iWriteData, iMemRData;
  logic [3:0]       iByteEn;
  logic [31:0]      oReadData, oMemAddr, oMemWData;
  logic             oStallM, oMemReq, oMemWe, iMemAck;
  logic [3:0]       oMemBe;
  logic [CNT_W-1:0] oHitCount, oMissCount;

  data_cache_m #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst(iRst), .iReadEn(iReadEn), .iWriteEn(iWriteEn),
    .iAddress(iAddress), .iWriteData(iWriteData), .iByteEn(iByteEn),
    .iInvalidate(iInvalidate), .oReadData(oReadData), .oStallM(oStallM),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory: unwritten words hold an address-derived pattern.
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return (a * 32'h0001_0193) ^ 32'hA5C3_1E00;
  endfunction

  // Cache model: which line (tag) is resident in each set.
  bit          mvalid [SETS];
  logic [23:0] mtag   [SETS];
  int          exp_hits, exp_misses;

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Memory responder: random ack latency, checks request stability and content.
  int          rd_reqs = 0, wr_reqs = 0, rd_in_line = 0;
  int          ack_min = 0, ack_max = 0, wait_cnt = 0;
  bit          waiting = 1'b0;
  logic [31:0] held_addr, wv;
  logic        held_we;

  always @(negedge iClk) begin
    if (iMemAck) waiting = 1'b0;
    iMemAck = 1'b0;
    if (iRst) begin
      waiting    = 1'b0;
      rd_in_line = 0;
    end else if (oMemReq) begin
      if (!waiting) begin
        waiting   = 1'b1;
        wait_cnt  = $urandom_range(ack_max, ack_min);
        held_addr = oMemAddr;
        held_we   = oMemWe;
        if (oMemWe) begin
          check("write_addr", oMemAddr, {iAddress[31:2], 2'b00});
          check("write_data", oMemWData, iWriteData);
          check("write_be", oMemBe, iByteEn);
        end else begin
          check("refill_addr", oMemAddr, {iAddress[31:4], 4'h0} + 32'(4 * rd_in_line));
        end
      end else begin
        check("req_addr_stable", oMemAddr, held_addr);
        check("req_we_stable", oMemWe, held_we);
      end
      if (wait_cnt == 0) begin
        iMemAck = 1'b1;
        if (held_we) begin
          wv = mem_rd(held_addr);
          for (int b = 0; b < 4; b++) if (iByteEn[b]) wv[8*b +: 8] = iWriteData[8*b +: 8];
          mem[held_addr[31:2]] = wv;
          wr_reqs++;
        end else begin
          iMemRData  = mem_rd(held_addr);
          rd_reqs++;
          rd_in_line = (rd_in_line + 1) % LINE_WORDS;
        end
      end else begin
        wait_cnt--;
      end
    end else begin
      waiting = 1'b0;
    end
  end

  int last_stall;

  // One pipeline access; called just after a rising edge, returns just after a rising edge.
  task automatic do_op(input bit rd, input bit wr, input bit inv, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int  rd0, wr0, n;
    bit  is_load, exp_hit;
    logic [3:0] s;
    is_load     = rd && !wr;
    s           = a[7:4];
    iReadEn     = rd;
    iWriteEn    = wr;
    iInvalidate = inv;
    iAddress    = a;
    iWriteData  = d;
    iByteEn     = be;
    if (inv) begin
      @(negedge iClk); #1;
      check("inv_stall", oStallM, rd || wr);
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      @(posedge iClk); #1;
      iInvalidate = 1'b0;
      if (!(rd || wr)) return;
    end
    rd0     = rd_reqs;
    wr0     = wr_reqs;
    exp_hit = mvalid[s] && (mtag[s] == a[31:8]);
    n       = 0;
    forever begin
      @(negedge iClk); #1;
      if (!oStallM) break;
      n++;
      if (n > 400) begin
        check("retire_timeout", n, 0);
        break;
      end
    end
    last_stall = n;
    if (is_load) check("load_data", oReadData, mem_rd(a));
    check("read_reqs", rd_reqs - rd0, (is_load && !exp_hit) ? LINE_WORDS : 0);
    check("write_reqs", wr_reqs - wr0, wr ? 1 : 0);
    if (is_load) begin
      if (exp_hit) begin
        if (exp_hits < CNT_MAX) exp_hits++;
      end else begin
        if (exp_misses < CNT_MAX) exp_misses++;
        mvalid[s] = 1'b1;
        mtag[s]   = a[31:8];
      end
    end
    @(posedge iClk); #1;
    iReadEn  = 1'b0;
    iWriteEn = 1'b0;
    check("hit_count", oHitCount, exp_hits);
    check("miss_count", oMissCount, exp_misses);
  endtask

  task automatic load(input logic [31:0] a);
    do_op(1'b1, 1'b0, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic apply_reset();
    iRst = 1'b1;
    iReadEn = 1'b0; iWriteEn = 1'b0; iInvalidate = 1'b0;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    model_reset();
  endtask

  initial begin
    int rd0, n, k;
    logic [31:0] a;
    iRst = 1'b1; iReadEn = 1'b0; iWriteEn = 1'b0; iInvalidate = 1'b0;
    iAddress = '0; iWriteData = '0; iByteEn = '0; iMemAck = 1'b0; iMemRData = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    model_reset();

    @(negedge iClk); #1;
    check("reset_stall", oStallM, 0);
    check("reset_req", oMemReq, 0);
    check("reset_we", oMemWe, 0);
    check("reset_hits", oHitCount, 0);
    check("reset_misses", oMissCount, 0);
    @(posedge iClk); #1;

    // Cold miss, then hits within the line, then an evicting tag.
    load(32'h100);
    check("t1_stall_cycles", last_stall, 1 + LINE_WORDS);
    load(32'h100);
    load(32'h104);
    check("t2_no_stall", last_stall, 0);
    load(32'h10C);
    load(32'h500);
    load(32'h100);

    // Partial store hit merges into the cached word; store miss does not allocate.
    do_op(1'b0, 1'b1, 1'b0, 32'h108, 32'hDEAD_BEEF, 4'b0011);
    load(32'h108);
    check("t3_merge_low", oReadData[15:0], 16'hBEEF);
    do_op(1'b0, 1'b1, 1'b0, 32'h2000, 32'h1234_5678, 4'b1111);
    load(32'h2000);
    check("t4_store_miss_refill", last_stall, 1 + LINE_WORDS);

    // Slow memory: stall covers every wait cycle of the refill.
    ack_min = 5; ack_max = 5;
    load(32'h3000);
    check("t5_stall_cycles", last_stall, 1 + LINE_WORDS * 6);

    // Reset after the second refill ack abandons the line.
    ack_min = 3; ack_max = 3;
    rd0 = rd_reqs;
    iReadEn = 1'b1; iAddress = 32'h740;
    n = 0;
    while (rd_reqs - rd0 < 2 && n < 100) begin
      @(negedge iClk); #1;
      n++;
    end
    check("t6_two_acks", rd_reqs - rd0, 2);
    @(posedge iClk); #1;
    apply_reset();
    @(negedge iClk); #1;
    check("t6_req_dropped", oMemReq, 0);
    check("t6_stall_idle", oStallM, 0);
    @(posedge iClk); #1;
    ack_min = 0; ack_max = 1;
    load(32'h740);
    load(32'h744);
    load(32'h100);
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    load(32'h744);
    do_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    load(32'h100);

    // Random mix over a small address pool so sets conflict and lines get reused.
    ack_min = 0; ack_max = 3;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      k = $urandom_range(0, 99);
      if (k < 60)      load(a);
      else if (k < 85) do_op(1'b0, 1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      else if (k < 90) do_op(1'b1, 1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      else if (k < 95) do_op(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
      else             do_op(1'b1, 1'b0, 1'b1, a, 32'h0, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
